// File: rtl/johnson_pkg.sv
// johnson_pkg: legal Johnson codes, lock FSM encoding and code helpers
package johnson_pkg;
  localparam logic [7:0][3:0] CODES = {4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                       4'b1110, 4'b1100, 4'b1000, 4'b0000};
  typedef enum logic [1:0] {ACQUIRE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} lock_state_t;
  function automatic logic [3:0] code_to_idx(input logic [3:0] code);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 0; i < 8; i++) if (code == CODES[3'(i)]) r = {1'b1, 3'(i)};
    return r;
  endfunction
  function automatic logic [3:0] next_code(input logic [3:0] code);
    logic [3:0] r;
    r = code_to_idx(code);
    return CODES[r[2:0] + 3'd1];
  endfunction
endpackage

// File: rtl/johnson_code_lut.sv
// johnson_code_lut: combinational Johnson code to valid/index/one-hot lookup
module johnson_code_lut
  import johnson_pkg::*;
(
  input  logic [3:0] code,
  output logic       valid,
  output logic [2:0] idx,
  output logic [7:0] onehot
);
  logic [3:0] r;
  always_comb begin
    r = code_to_idx(code);
    valid = r[3];
    idx = r[2:0];
    onehot = r[3] ? 8'b1 << r[2:0] : 8'b0;
  end
endmodule

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder: registers a Johnson code, decodes phase, checks sequence, tracks lock and revolutions
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int LOCK_LEN = 8,
  parameter int REV_W = 8
) (
  input  logic             CLK1,
  input  logic             reset,
  input  logic             Q1,
  input  logic             Q2,
  input  logic             Q3,
  input  logic             Q4,
  input  logic             err_clr,
  output logic [7:0]       phase,
  output logic [2:0]       phase_idx,
  output logic             code_valid,
  output logic             wrap,
  output logic [REV_W-1:0] rev_count,
  output logic             lock,
  output logic             err,
  output logic             err_sticky
);
  logic [3:0] cur, prev;
  logic cur_v, prev_v;
  logic cur_ok, prev_ok;
  logic [2:0] cur_idx, prev_idx;
  logic [7:0] cur_oh, prev_oh;
  lock_state_t state, state_n;
  logic [7:0] step_cnt, cnt_n;
  logic chk, hold, step, bad, err_set, wrap_n;
  johnson_code_lut u_cur (.code(cur), .valid(cur_ok), .idx(cur_idx), .onehot(cur_oh));
  johnson_code_lut u_prev (.code(prev), .valid(prev_ok), .idx(prev_idx), .onehot(prev_oh));
  // Steps are only judged against a legal predecessor; after an illegal code the FSM restarts from ACQUIRE anyway
  assign chk = cur_v & prev_v & prev_ok;
  assign hold = cur_ok & (cur_oh == prev_oh);
  assign step = cur_ok & (cur == next_code(prev));
  assign bad = ~(hold | step);
  assign lock = state == LOCKED;
  always_comb begin
    state_n = state;
    cnt_n = step_cnt;
    err_set = 1'b0;
    wrap_n = chk & step & (prev_idx == 3'd7) & (state != ACQUIRE);
    if (state == ACQUIRE) begin
      state_n = cur_v & cur_ok ? TRACK : ACQUIRE;
      cnt_n = 8'd0;
      err_set = cur_v & ~cur_ok;
    end else if (chk & bad) begin
      state_n = ACQUIRE;
      cnt_n = 8'd0;
      err_set = 1'b1;
    end else if (chk & step & (state == TRACK)) begin
      cnt_n = step_cnt + 8'd1;
      state_n = cnt_n == 8'(LOCK_LEN) ? LOCKED : TRACK;
    end
  end
  always_ff @(posedge CLK1 or posedge reset) begin
    if (reset) begin
      cur <= 4'b0;
      prev <= 4'b0;
      cur_v <= 1'b0;
      prev_v <= 1'b0;
      state <= ACQUIRE;
      step_cnt <= 8'd0;
      phase <= 8'b0;
      phase_idx <= 3'd0;
      code_valid <= 1'b0;
      wrap <= 1'b0;
      rev_count <= '0;
      err <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      cur <= {Q1, Q2, Q3, Q4};
      prev <= cur;
      cur_v <= 1'b1;
      prev_v <= cur_v;
      state <= state_n;
      step_cnt <= cnt_n;
      phase <= cur_v ? cur_oh : 8'b0;
      phase_idx <= cur_v ? cur_idx : 3'd0;
      code_valid <= cur_v & cur_ok;
      wrap <= wrap_n;
      rev_count <= rev_count + REV_W'(wrap_n);
      err <= err_set;
      err_sticky <= err_set | (err_sticky & ~err_clr);
    end
  end
endmodule
